// File: rtl/full_adder_pkg.sv
// Shared constants and the 1-bit full-adder equation used by the adder cell
// and by reference models.
package full_adder_pkg;
  localparam int FA_MAX_WIDTH = 64;

  // Returns {carry, sum}.
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction
endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle of the registered ripple-carry adder.
// Port ovf exists only when FULL_ADDER_OVF_EN is defined.
interface full_adder_if #(parameter int WIDTH = 1);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, x, y, cin,
    input  Sum, Cout, out_valid
`ifdef FULL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, x, y, cin,
    output Sum, Cout, out_valid
`ifdef FULL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/full_adder_bit.sv
// Purely combinational 1-bit full-adder cell; one link of the ripple chain.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign {co, s} = fa_bit(a, b, ci);
endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {Cout,Sum} <= x + y + cin on enabled edges.
// Optional registered signed overflow output under FULL_ADDER_OVF_EN.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic       clk,
  input logic       rst,
  full_adder_if.slave bus
);
  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_bit (
      .a (bus.x[i]),
      .b (bus.y[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end

  // Result registers load only on valid edges, so idle-cycle operand garbage never reaches them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Sum       <= '0;
      bus.Cout      <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Sum  <= s;
        bus.Cout <= c[WIDTH];
`ifdef FULL_ADDER_OVF_EN
        bus.ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Directed/table-driven bench for full_adder at WIDTH=1, 8 and 16.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1))  b1();
  full_adder_if #(.WIDTH(8))  b8();
  full_adder_if #(.WIDTH(16)) b16();

  full_adder #(.WIDTH(1))  u_fa1  (.clk(clk), .rst(rst), .bus(b1.slave));
  full_adder #(.WIDTH(8))  u_fa8  (.clk(clk), .rst(rst), .bus(b8.slave));
  full_adder #(.WIDTH(16)) u_fa16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic x, y, cin;
    logic s, c;
  } vec1_t;

  typedef struct {
    logic [7:0] x, y;
    logic       cin;
    logic [7:0] s;
    logic       c, ov;
  } vec8_t;

  vec1_t v1 [8];
  vec8_t v8 [5];

  logic [15:0] rx, ry;
  logic        rc;
  logic [16:0] rexp;

  initial begin
    v1[0] = '{0,0,0, 0,0}; v1[1] = '{0,0,1, 1,0};
    v1[2] = '{0,1,0, 1,0}; v1[3] = '{0,1,1, 0,1};
    v1[4] = '{1,0,0, 1,0}; v1[5] = '{1,0,1, 0,1};
    v1[6] = '{1,1,0, 0,1}; v1[7] = '{1,1,1, 1,1};
    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[1] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    v8[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v8[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};

    b1.in_valid = 0;  b1.x = '0;  b1.y = '0;  b1.cin = 0;
    b8.in_valid = 0;  b8.x = '0;  b8.y = '0;  b8.cin = 0;
    b16.in_valid = 0; b16.x = '0; b16.y = '0; b16.cin = 0;

    // Reset state before any clock edge
    #3;
    chk("rst_sum1", b1.Sum, 0);   chk("rst_cout1", b1.Cout, 0);
    chk("rst_vld1", b1.out_valid, 0);
    chk("rst_sum8", b8.Sum, 0);   chk("rst_vld16", b16.out_valid, 0);
`ifdef FULL_ADDER_OVF_EN
    chk("rst_ovf8", b8.ovf, 0);
`endif
    @(negedge clk); rst = 0;
    // Idle edge after release keeps reset values
    @(posedge clk); #1;
    chk("rel_sum1", b1.Sum, 0); chk("rel_vld1", b1.out_valid, 0);

    // WIDTH=1 exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b1.in_valid = 1; b1.x = v1[i].x; b1.y = v1[i].y; b1.cin = v1[i].cin;
      @(posedge clk); #1;
      chk($sformatf("w1_sum[%0d]", i), b1.Sum, v1[i].s);
      chk($sformatf("w1_cout[%0d]", i), b1.Cout, v1[i].c);
      chk($sformatf("w1_vld[%0d]", i), b1.out_valid, 1);
    end

    // Async reset between edges
    @(negedge clk); b1.x = 1; b1.y = 1; b1.cin = 1;
    @(posedge clk); #1;
    chk("pre_rst_sum", b1.Sum, 1); chk("pre_rst_cout", b1.Cout, 1);
    @(negedge clk); b1.in_valid = 0;
    #1 rst = 1;
    #1;
    chk("arst_sum", b1.Sum, 0); chk("arst_cout", b1.Cout, 0);
    chk("arst_vld", b1.out_valid, 0);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("post_rst_sum", b1.Sum, 0); chk("post_rst_vld", b1.out_valid, 0);

    // Operand presented while rst is held across the edge is discarded
    @(negedge clk); b1.in_valid = 1; rst = 1;
    @(posedge clk); #1;
    chk("discard_sum", b1.Sum, 0); chk("discard_vld", b1.out_valid, 0);
    @(negedge clk); rst = 0; b1.in_valid = 0;

    // Hold: capture 1+0+0 then idle with all-ones operands
    @(negedge clk); b1.in_valid = 1; b1.x = 1; b1.y = 0; b1.cin = 0;
    @(posedge clk); #1;
    chk("hold_cap_sum", b1.Sum, 1); chk("hold_cap_vld", b1.out_valid, 1);
    @(negedge clk); b1.in_valid = 0; b1.x = 1; b1.y = 1; b1.cin = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_sum[%0d]", k), b1.Sum, 1);
      chk($sformatf("hold_cout[%0d]", k), b1.Cout, 0);
      chk($sformatf("hold_vld[%0d]", k), b1.out_valid, 0);
    end

    // WIDTH=8 carry chain and overflow vectors
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b8.in_valid = 1; b8.x = v8[i].x; b8.y = v8[i].y; b8.cin = v8[i].cin;
      @(posedge clk); #1;
      chk($sformatf("w8_sum[%0d]", i), b8.Sum, v8[i].s);
      chk($sformatf("w8_cout[%0d]", i), b8.Cout, v8[i].c);
      chk($sformatf("w8_vld[%0d]", i), b8.out_valid, 1);
`ifdef FULL_ADDER_OVF_EN
      chk($sformatf("w8_ovf[%0d]", i), b8.ovf, v8[i].ov);
`endif
    end
    @(negedge clk); b8.in_valid = 0; b8.x = 8'h7F; b8.y = 8'h7F;
    @(posedge clk); #1;
    chk("w8_hold_sum", b8.Sum, 8'h00); chk("w8_hold_cout", b8.Cout, 1);
`ifdef FULL_ADDER_OVF_EN
    chk("w8_hold_ovf", b8.ovf, 0);
`endif

    // WIDTH=16 random back-to-back regression
    rexp = '0;
    for (int k = 0; k <= 10000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("w16_res[%0d]", k - 1), {b16.Cout, b16.Sum}, rexp);
        chk($sformatf("w16_vld[%0d]", k - 1), b16.out_valid, 1);
      end
      if (k < 10000) begin
        rx = 16'($urandom); ry = 16'($urandom); rc = 1'($urandom);
        b16.in_valid = 1; b16.x = rx; b16.y = ry; b16.cin = rc;
        rexp = 17'(rx) + 17'(ry) + 17'(rc);
      end else begin
        b16.in_valid = 0;
      end
    end
    @(posedge clk); #1;
    chk("w16_idle_vld", b16.out_valid, 0);
    chk("w16_idle_hold", {b16.Cout, b16.Sum}, rexp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
